// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer between decode and fetch: waits for valid ALU flags,
// resolves the branch, redirects the PC and flushes wrong-path stages on a taken branch.
module branch_sequencer #(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 15,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              flags_valid,
  input  logic [1:0]        flags,
  output logic              busy,
  output logic              stall_if,
  output logic              pc_branch_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [4:0] OP_BEQ = 5'b10011;
  localparam logic [4:0] OP_BNE = 5'b10110;
  localparam logic [4:0] OP_BLT = 5'b10100;
  localparam logic [4:0] OP_BGT = 5'b10101;

  localparam int WW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int FW         = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FLUSH_LAST = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

  typedef enum logic [1:0] {IDLE, WAIT_FLAGS, REDIRECT, FLUSH} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      opcode_reg, opcode_next;
  logic [ADDR_W-1:0] target_next;
  logic [WW-1:0]   wait_reg, wait_next;
  logic [FW-1:0]   flush_reg, flush_next;
  logic            resolve, resolve_taken, timeout_set;

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGT);
  endfunction

  // flags[1] is Z, flags[0] is N
  function automatic logic branch_taken(input logic [4:0] op, input logic [1:0] fl);
    logic t;
    case (op)
      OP_BEQ:  t = fl[1];
      OP_BNE:  t = ~fl[1];
      OP_BLT:  t = fl[0];
      OP_BGT:  t = ~fl[0];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_comb begin
    state_next    = state_reg;
    opcode_next   = opcode_reg;
    target_next   = pc_target;
    wait_next     = wait_reg;
    flush_next    = flush_reg;
    resolve       = 1'b0;
    resolve_taken = 1'b0;
    timeout_set   = 1'b0;
    busy          = 1'b0;
    stall_if      = 1'b0;
    pc_branch_sel = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (id_valid && is_branch(id_opcode)) begin
          opcode_next = id_opcode;
          target_next = id_target;
          if (flags_valid) begin
            resolve       = 1'b1;
            resolve_taken = branch_taken(id_opcode, flags);
            if (resolve_taken) state_next = REDIRECT;
          end else begin
            state_next = WAIT_FLAGS;
            wait_next  = '0;
          end
        end
      end
      WAIT_FLAGS: begin
        busy     = 1'b1;
        stall_if = 1'b1;
        // Valid flags win over a timeout landing in the same cycle.
        if (flags_valid) begin
          resolve       = 1'b1;
          resolve_taken = branch_taken(opcode_reg, flags);
          state_next    = resolve_taken ? REDIRECT : IDLE;
        end else if (wait_reg == WW'(TIMEOUT - 1)) begin
          resolve     = 1'b1;
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else begin
          wait_next = wait_reg + WW'(1);
        end
      end
      REDIRECT: begin
        busy          = 1'b1;
        pc_branch_sel = 1'b1;
        flush_if_id   = 1'b1;
        flush_id_ex   = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_next = FLUSH;
          flush_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      FLUSH: begin
        busy        = 1'b1;
        flush_if_id = 1'b1;
        if (flush_reg == FW'(FLUSH_LAST)) state_next = IDLE;
        else flush_next = flush_reg + FW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      opcode_reg  <= '0;
      pc_target   <= '0;
      wait_reg    <= '0;
      flush_reg   <= '0;
      timeout_err <= 1'b0;
      branch_cnt  <= '0;
      taken_cnt   <= '0;
    end else begin
      state_reg  <= state_next;
      opcode_reg <= opcode_next;
      pc_target  <= target_next;
      wait_reg   <= wait_next;
      flush_reg  <= flush_next;
      if (timeout_set) timeout_err <= 1'b1;
      if (resolve) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
        if (resolve_taken) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: expected resolutions are queued at stimulus time
// and popped when the sequencer resolves the branch.
module tb_branch_sequencer;

  localparam int ADDR_W       = 16;
  localparam int FLUSH_CYCLES = 2;
  localparam int TIMEOUT      = 15;
  localparam logic [4:0] BEQ = 5'b10011;
  localparam logic [4:0] BNE = 5'b10110;
  localparam logic [4:0] BLT = 5'b10100;
  localparam logic [4:0] BGT = 5'b10101;

  logic clk = 1'b0;
  logic rst_n, rst2_n;
  logic id_valid, flags_valid;
  logic [4:0] id_opcode;
  logic [ADDR_W-1:0] id_target;
  logic [1:0] flags;
  logic busy, stall_if, pc_branch_sel, flush_if_id, flush_id_ex, timeout_err;
  logic [ADDR_W-1:0] pc_target;
  logic [15:0] branch_cnt, taken_cnt;
  logic busy2, stall_if2, pc_branch_sel2, flush_if_id2, flush_id_ex2, timeout_err2;
  logic [ADDR_W-1:0] pc_target2;
  logic [1:0] branch_cnt2, taken_cnt2;

  branch_sequencer #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_target(id_target),
    .flags_valid(flags_valid), .flags(flags), .busy(busy), .stall_if(stall_if),
    .pc_branch_sel(pc_branch_sel), .pc_target(pc_target), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .timeout_err(timeout_err), .branch_cnt(branch_cnt),
    .taken_cnt(taken_cnt)
  );

  branch_sequencer #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(1), .TIMEOUT(TIMEOUT), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_target(id_target),
    .flags_valid(flags_valid), .flags(flags), .busy(busy2), .stall_if(stall_if2),
    .pc_branch_sel(pc_branch_sel2), .pc_target(pc_target2), .flush_if_id(flush_if_id2),
    .flush_id_ex(flush_id_ex2), .timeout_err(timeout_err2), .branch_cnt(branch_cnt2),
    .taken_cnt(taken_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          taken;
    logic [15:0] target;
    bit          tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_branch = 0;
  int   exp_taken = 0;
  int   exp_taken2 = 0;
  int   exp_branch2 = 0;
  bit   chk2 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_taken(input logic [4:0] op, input logic [1:0] fl);
    bit z, n;
    z = fl[1];
    n = fl[0];
    if (op == BEQ) return z;
    if (op == BNE) return !z;
    if (op == BLT) return n;
    if (op == BGT) return !n;
    return 1'b0;
  endfunction

  task automatic check_counters();
    chk("branch_cnt", 32'(branch_cnt), 32'(exp_branch % 65536));
    chk("taken_cnt", 32'(taken_cnt), 32'(exp_taken % 65536));
  endtask

  task automatic do_reset(input bit both);
    rst_n = 1'b0;
    if (both) rst2_n = 1'b0;
    #1;
    chk("reset_ctrl", 32'({busy, stall_if, pc_branch_sel, flush_if_id, flush_id_ex, timeout_err}), 32'd0);
    chk("reset_target", 32'(pc_target), 32'd0);
    exp_branch = 0;
    exp_taken  = 0;
    if (both) begin
      exp_branch2 = 0;
      exp_taken2  = 0;
    end
    sb.delete();
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;
    if (both) rst2_n = 1'b1;
    tick();
  endtask

  // n_wait = number of WAIT_FLAGS cycles; flags become valid in the last one.
  task automatic run_branch(input logic [4:0] op, input logic [15:0] tgt,
                            input logic [1:0] fl, input int n_wait);
    exp_t e;
    int stalls;
    e.taken  = model_taken(op, fl);
    e.target = tgt;
    e.tmo    = 1'b0;
    sb.push_back(e);
    id_valid = 1'b1; id_opcode = op; id_target = tgt; flags = fl;
    flags_valid = (n_wait == 0);
    tick();
    id_valid  = 1'b0;
    id_target = ~tgt;
    stalls = 0;
    for (int i = 0; i < n_wait; i++) begin
      if (stall_if === 1'b1) stalls++;
      if (i == n_wait - 1) flags_valid = 1'b1;
      tick();
    end
    chk("stall_cycles", 32'(stalls), 32'(n_wait));
    e = sb.pop_front();
    exp_branch++;
    exp_branch2 = (exp_branch2 + 1) % 4;
    if (e.taken) begin
      exp_taken++;
      exp_taken2 = (exp_taken2 + 1) % 4;
    end
    check_counters();
    if (e.taken) begin
      chk("redirect", 32'({busy, pc_branch_sel, flush_if_id, flush_id_ex, stall_if}), 32'b11110);
      chk("pc_target", 32'(pc_target), 32'(e.target));
      if (chk2) chk("dut2_redirect", 32'({pc_branch_sel2, flush_if_id2}), 32'b11);
      for (int i = 0; i < FLUSH_CYCLES - 1; i++) begin
        tick();
        chk("flush_hold", 32'({pc_branch_sel, flush_id_ex, flush_if_id, busy}), 32'b0011);
        if (chk2 && i == 0) chk("dut2_flush_single", 32'({flush_if_id2, busy2}), 32'd0);
      end
    end else begin
      chk("no_redirect", 32'({pc_branch_sel, flush_if_id, flush_id_ex, busy}), 32'd0);
    end
    tick();
    chk("idle_after", 32'({busy, stall_if, flush_if_id}), 32'd0);
    flags_valid = 1'b0;
  endtask

  task automatic run_timeout(input logic [4:0] op, input logic [15:0] tgt);
    exp_t e;
    int stalls;
    e.taken = 1'b0; e.target = tgt; e.tmo = 1'b1;
    sb.push_back(e);
    id_valid = 1'b1; id_opcode = op; id_target = tgt; flags_valid = 1'b0;
    tick();
    id_valid = 1'b0;
    stalls = 0;
    for (int i = 0; i < TIMEOUT + 3; i++) begin
      if (stall_if !== 1'b1) break;
      stalls++;
      tick();
    end
    chk("timeout_stalls", 32'(stalls), 32'(TIMEOUT));
    e = sb.pop_front();
    exp_branch++;
    exp_branch2 = (exp_branch2 + 1) % 4;
    chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
    chk("timeout_no_redirect", 32'({pc_branch_sel, flush_if_id, busy}), 32'd0);
    check_counters();
    tick();
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    id_valid = 1'b0; id_opcode = '0; id_target = '0; flags_valid = 1'b0; flags = '0;
    tick();
    chk("reset_ctrl", 32'({busy, stall_if, pc_branch_sel, flush_if_id, flush_id_ex, timeout_err}), 32'd0);
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_branch(BEQ, 16'h1234, 2'b10, 0);
    run_branch(BNE, 16'h2222, 2'b11, 0);
    run_branch(BGT, 16'h3333, 2'b01, 0);
    run_branch(BEQ, 16'h0abc, 2'b00, 0);
    run_branch(BNE, 16'h0bcd, 2'b00, 0);
    run_branch(BGT, 16'h0cde, 2'b00, 0);
    run_branch(BLT, 16'h0def, 2'b00, 0);
    run_branch(BLT, 16'h4444, 2'b01, 3);
    run_branch(BGT, 16'h5555, 2'b01, 0);
    run_timeout(BNE, 16'h6666);
    run_branch(BEQ, 16'h6789, 2'b10, TIMEOUT);

    // Reset while waiting for flags.
    id_valid = 1'b1; id_opcode = BLT; id_target = 16'h7777; flags_valid = 1'b0;
    tick();
    id_valid = 1'b0;
    chk("wait_before_reset", 32'(stall_if), 32'd1);
    do_reset(1'b0);

    // Reset while flushing.
    id_valid = 1'b1; id_opcode = BEQ; id_target = 16'h8888; flags = 2'b10; flags_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    tick();
    chk("flush_before_reset", 32'({busy, flush_if_id, pc_branch_sel}), 32'b110);
    do_reset(1'b0);

    // Non-branch opcodes are ignored.
    id_valid = 1'b1; id_opcode = 5'b00000; flags = 2'b10; flags_valid = 1'b1;
    tick();
    chk("ignore_op0", 32'({busy, pc_branch_sel}), 32'd0);
    id_opcode = 5'b10111;
    tick();
    tick();
    chk("ignore_op17", 32'({busy, pc_branch_sel}), 32'd0);
    id_valid = 1'b0; flags_valid = 1'b0;
    check_counters();

    // Narrow-counter and single-cycle-flush instance alongside the default one.
    do_reset(1'b1);
    chk2 = 1'b1;
    for (int i = 0; i < 5; i++) run_branch(BEQ, 16'h7000 + 16'(i), 2'b10, 0);
    chk("dut2_taken_wrap", 32'(taken_cnt2), 32'(exp_taken2));
    chk("dut2_branch_wrap", 32'(branch_cnt2), 32'(exp_branch2));
    chk("dut2_pc_target", 32'(pc_target2), 32'h7004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
